// File: rtl/apb_timer_pkg.sv
// Shared widths, register map, bit positions and APB state type for the APB timer slave.
// Optional prescaler is enabled by defining TIMER_PRESCALE_EN.
package apb_timer_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned PRESCALE_W = 8;

    localparam logic [ADDR_W-1:0] OFF_CTRL   = ADDR_W'(32'h0);
    localparam logic [ADDR_W-1:0] OFF_LOAD   = ADDR_W'(32'h4);
    localparam logic [ADDR_W-1:0] OFF_COUNT  = ADDR_W'(32'h8);
    localparam logic [ADDR_W-1:0] OFF_STATUS = ADDR_W'(32'hC);

    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;
    localparam int unsigned CTRL_PSC_LSB     = 8;

    localparam int unsigned STAT_EXPIRED = 0;
    localparam int unsigned STAT_RUNNING = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_timer_core.sv
// Down-counter with reload, expiry strobe and optional prescaler (TIMER_PRESCALE_EN).
module apb_timer_core
    import apb_timer_pkg::*;
(
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  en,
    input  logic                  auto_reload,
`ifdef TIMER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  ctrl_wr,
`endif
    input  logic                  load_wr,
    input  logic [DATA_W-1:0]     load_wdata,
    input  logic [DATA_W-1:0]     load_val,
    output logic [DATA_W-1:0]     count,
    output logic                  expire_c
);

    logic tick_c;

`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] psc_cnt;

    // Restart the prescale window whenever the timer is stopped or reprogrammed
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psc_cnt <= '0;
        end else if (!en || ctrl_wr || load_wr || (psc_cnt == prescale)) begin
            psc_cnt <= '0;
        end else begin
            psc_cnt <= psc_cnt + PRESCALE_W'(1);
        end
    end

    assign tick_c = en && (psc_cnt == prescale);
`else
    assign tick_c = en;
`endif

    // A LOAD write overrides the tick, so it also suppresses expiry
    assign expire_c = tick_c && !load_wr && (count == DATA_W'(1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            count <= '0;
        end else if (load_wr) begin
            count <= load_wdata;
        end else if (tick_c && (count > DATA_W'(1))) begin
            count <= count - DATA_W'(1);
        end else if (expire_c) begin
            count <= auto_reload ? load_val : '0;
        end
    end

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB3 slave hosting CTRL/LOAD/COUNT/STATUS of a down-counting timer.
// Define TIMER_PRESCALE_EN to add the CTRL[15:8] prescaler.
module apb_timer_slave
    import apb_timer_pkg::*;
(
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              irq
);

    apb_state_t        state, state_d;
    logic              setup_rd_c, access_c;
    logic              ctrl_wr_c, load_wr_c, status_wr_c;
    logic [ADDR_W-1:0] reg_addr;
    logic              en_q, auto_reload_q, irq_en_q, expired_q;
    logic              en_d, auto_reload_d, irq_en_d, expired_d;
    logic [DATA_W-1:0] load_q, count, rdata_c;
    logic              expire_c;
    logic              unused_paddr;
`ifdef TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
`endif

    assign reg_addr     = {PADDR[ADDR_W-1:2], 2'b00};
    assign unused_paddr = ^PADDR[1:0];

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // APB phase tracking; an access strobe without a preceding setup is dropped
    always_comb begin
        state_d     = IDLE;
        access_c    = 1'b0;
        ctrl_wr_c   = 1'b0;
        load_wr_c   = 1'b0;
        status_wr_c = 1'b0;
        setup_rd_c  = PSEL && !PENABLE && !PWRITE;
        case (state)
            IDLE:   if (PSEL && !PENABLE) state_d = SETUP;
            SETUP: begin
                if (PSEL && PENABLE) begin
                    state_d  = ACCESS;
                    access_c = 1'b1;
                end else if (PSEL) begin
                    state_d = SETUP;
                end
            end
            ACCESS: if (PSEL && !PENABLE) state_d = SETUP;
            default: state_d = IDLE;
        endcase
        if (access_c && PWRITE) begin
            ctrl_wr_c   = (reg_addr == OFF_CTRL);
            load_wr_c   = (reg_addr == OFF_LOAD);
            status_wr_c = (reg_addr == OFF_STATUS);
        end
    end

    // Expiry set wins over a same-cycle W1C
    always_comb begin
        en_d          = en_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
`ifdef TIMER_PRESCALE_EN
        prescale_d    = prescale_q;
`endif
        if (ctrl_wr_c) begin
            en_d          = PWDATA[CTRL_EN];
            auto_reload_d = PWDATA[CTRL_AUTO_RELOAD];
            irq_en_d      = PWDATA[CTRL_IRQ_EN];
`ifdef TIMER_PRESCALE_EN
            prescale_d    = PWDATA[CTRL_PSC_LSB +: PRESCALE_W];
`endif
        end
        expired_d = expire_c || (expired_q && !(status_wr_c && PWDATA[STAT_EXPIRED]));
    end

    always_comb begin
        rdata_c = '0;
        case (reg_addr)
            OFF_CTRL: begin
                rdata_c[CTRL_EN]          = en_q;
                rdata_c[CTRL_AUTO_RELOAD] = auto_reload_q;
                rdata_c[CTRL_IRQ_EN]      = irq_en_q;
`ifdef TIMER_PRESCALE_EN
                rdata_c[CTRL_PSC_LSB +: PRESCALE_W] = prescale_q;
`endif
            end
            OFF_LOAD:  rdata_c = load_q;
            OFF_COUNT: rdata_c = count;
            OFF_STATUS: begin
                rdata_c[STAT_EXPIRED] = expired_q;
                rdata_c[STAT_RUNNING] = en_q && (count != '0);
            end
            default: rdata_c = '0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q          <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            expired_q     <= 1'b0;
            load_q        <= '0;
            irq           <= 1'b0;
            PRDATA        <= '0;
`ifdef TIMER_PRESCALE_EN
            prescale_q    <= '0;
`endif
        end else begin
            en_q          <= en_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            expired_q     <= expired_d;
            irq           <= expired_d && irq_en_d;
`ifdef TIMER_PRESCALE_EN
            prescale_q    <= prescale_d;
`endif
            if (load_wr_c) begin
                load_q <= PWDATA;
            end
            if (setup_rd_c) begin
                PRDATA <= rdata_c;
            end else if (access_c) begin
                PRDATA <= '0;
            end
        end
    end

    apb_timer_core u_core (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .en          (en_q),
        .auto_reload (auto_reload_q),
`ifdef TIMER_PRESCALE_EN
        .prescale    (prescale_q),
        .ctrl_wr     (ctrl_wr_c),
`endif
        .load_wr     (load_wr_c),
        .load_wdata  (PWDATA),
        .load_val    (load_q),
        .count       (count),
        .expire_c    (expire_c)
    );

endmodule
